tl_cntr_param: RTL and testbench

TL_CNTR_PARAM -- requirements
Module: tl_cntr_param

---
 rtl/tl_pkg.sv | 11 +
 rtl/tl_phase_timer.sv | 18 +
 rtl/tl_cntr_param.sv | 72 +++++++
 tb/tb_tl_cntr_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: light codes, phase enum and phase-to-light lookup for the traffic controller
package tl_pkg;
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] LEFT   = 2'b11;
  typedef enum logic [1:0] {SG, SY, LG, LY} tl_state_e;
  function automatic logic [1:0] light_code(tl_state_e s);
    return s == SG ? GREEN : s == LG ? LEFT : YELLOW;
  endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: phase dwell counter, cleared on clr, saturating at LIMIT
//   clk, reset (async, active-high) | clr: restart at 0 next cycle | cnt: cycles spent in phase
module tl_phase_timer #(
  parameter int LIMIT = 7,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : (cnt_q == W'(LIMIT)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/tl_cntr_param.sv
// tl_cntr_param: round-robin N_DIR-way traffic light controller with straight and left-arrow phases
//   clk, reset (async, active-high) | T, TL: straight / left-turn demand per direction
//   L: 2-bit light code per direction | dir: direction currently served
//   Build option: define TL_LEFT_SKIP_EN to skip the left-arrow phase when no left demand exists.
module tl_cntr_param import tl_pkg::*; #(
  parameter int N_DIR   = 2,
  parameter int MIN_GRN = 3,
  parameter int MAX_GRN = 8,
  parameter int YEL_CYC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           T,
  input  logic [N_DIR-1:0]           TL,
  output logic [2*N_DIR-1:0]         L,
  output logic [$clog2(N_DIR)-1:0]   dir
);
  localparam int DW = $clog2(N_DIR);
  localparam int CW = $clog2(MAX_GRN);
  tl_state_e     state_q, state_d;
  logic [DW-1:0] dir_q, dir_d, dir_nx;
  logic [CW-1:0] cnt;
  logic          dem, grn_done, yel_done, skip, clr;
  tl_phase_timer #(.LIMIT(MAX_GRN - 1), .W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .cnt   (cnt)
  );
  // demand only matters in SG/LG; yellow exits purely on time
  assign dem      = (state_q == LG) ? TL[dir_q] : T[dir_q];
  assign grn_done = (cnt >= CW'(MIN_GRN - 1) && !dem) || cnt == CW'(MAX_GRN - 1);
  assign yel_done = cnt == CW'(YEL_CYC - 1);
  assign dir_nx   = (dir_q == DW'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
`ifdef TL_LEFT_SKIP_EN
  assign skip = !TL[dir_q];
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      SG: state_d = grn_done ? SY : SG;
      SY: if (yel_done) begin
        state_d = skip ? SG : LG;
        dir_d   = skip ? dir_nx : dir_q;
      end
      LG: state_d = grn_done ? LY : LG;
      default: if (yel_done) begin
        state_d = SG;
        dir_d   = dir_nx;
      end
    endcase
  end
  // every direction change coincides with a state change, so this restarts the dwell timer
  assign clr = state_d != state_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= SG;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  always_comb begin
    L = '0;
    for (int i = 0; i < N_DIR; i++)
      L[2*i +: 2] = (DW'(i) == dir_q) ? light_code(state_q) : RED;
  end
  assign dir = dir_q;
endmodule

// File: tb/tb_tl_cntr_param.sv
// tb_tl_cntr_param: randomized and directed checks of tl_cntr_param against a dwell-time model
module tb_tl_cntr_param;
  localparam int MIN = 3, MAX = 8, YEL = 2;
  typedef struct {int d; int ph; int el;} mdl_t;
  logic       clk = 0, reset = 1;
  logic [1:0] T2 = '0, TL2 = '0, L2_0;
  logic [3:0] L2;
  logic       dir2;
  logic [2:0] T3 = '0, TL3 = '0;
  logic [5:0] L3;
  logic [1:0] dir3;
  int tests = 0, fails = 0;
  mdl_t m2, m3;
  tl_cntr_param #(.N_DIR(2)) dut2 (.clk(clk), .reset(reset), .T(T2), .TL(TL2), .L(L2), .dir(dir2));
  tl_cntr_param #(.N_DIR(3)) dut3 (.clk(clk), .reset(reset), .T(T3), .TL(TL3), .L(L3), .dir(dir3));
  always #5 clk = ~clk;
  // phases: 0 green, 1 yellow, 2 arrow, 3 arrow yellow; el = cycles already spent in phase
  function automatic mdl_t step(mdl_t m, logic [3:0] t, logic [3:0] tl, int n);
    mdl_t r;
    int dw;
    bit dem, done;
    r = m;
    dw = m.el + 1;
    dem = (m.ph == 2) ? tl[m.d] : t[m.d];
    done = (m.ph % 2 == 0) ? ((dw >= MIN && !dem) || dw >= MAX) : (dw == YEL);
    r.el = done ? 0 : m.el + 1;
    if (done)
      case (m.ph)
        0: r.ph = 1;
        1: begin
          r.ph = 2;
`ifdef TL_LEFT_SKIP_EN
          if (!tl[m.d]) begin r.ph = 0; r.d = (m.d + 1) % n; end
`endif
        end
        2: r.ph = 3;
        default: begin r.ph = 0; r.d = (m.d + 1) % n; end
      endcase
    return r;
  endfunction
  function automatic logic [7:0] light(mdl_t m);
    logic [7:0] r;
    r = 8'hAA;
    r[2*m.d +: 2] = m.ph == 0 ? 2'b00 : m.ph == 2 ? 2'b11 : 2'b01;
    return r;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m2 <= '{0, 0, 0};
      m3 <= '{0, 0, 0};
    end else begin
      m2 <= step(m2, {2'b0, T2}, {2'b0, TL2}, 2);
      m3 <= step(m3, {1'b0, T3}, {1'b0, TL3}, 3);
    end
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask
  task automatic tick();
    logic [7:0] e2, e3;
    @(negedge clk);
    e2 = light(m2);
    e3 = light(m3);
    chk("L2", {28'b0, L2}, {28'b0, e2[3:0]});
    chk("dir2", {31'b0, dir2}, m2.d);
    chk("L3", {26'b0, L3}, {26'b0, e3[5:0]});
    chk("dir3", {30'b0, dir3}, m3.d);
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic green_run(input bit drop, output int n);
    n = 0;
    while (L2[1:0] == 2'b00 && n < 40) begin
      if (drop && n == 5) T2[0] = 1'b0;
      n++;
      tick();
    end
  endtask
  initial begin
    logic [1:0] s [35];
    int d3 [35];
    int chg [$];
    int n, p;
    logic [1:0] e;
    tick();
    tick();
    chk("rst_L2", {28'b0, L2}, 32'h8);
    chk("rst_dir2", {31'b0, dir2}, 0);
    chk("rst_L3", {26'b0, L3}, 32'h28);
    reset = 0;
    for (int k = 0; k < 35; k++) begin
      s[k] = L2[1:0];
      d3[k] = dir3;
      tick();
    end
    for (int k = 0; k < 21; k++) begin
`ifdef TL_LEFT_SKIP_EN
      p = k % 10;
      e = p < 3 ? 2'b00 : p < 5 ? 2'b01 : 2'b10;
`else
      p = k % 20;
      e = p < 3 ? 2'b00 : p < 5 ? 2'b01 : p < 8 ? 2'b11 : p < 10 ? 2'b01 : 2'b10;
`endif
      chk($sformatf("dir0_seq%0d", k), {30'b0, s[k]}, {30'b0, e});
    end
    chg.push_back(d3[0]);
    for (int k = 1; k < 35; k++) if (d3[k] != d3[k-1]) chg.push_back(d3[k]);
    chk("dir3_n", chg.size() >= 4, 1);
    if (chg.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("dir3_seq%0d", k), chg[k], k % 3);
    T2 = 2'b01;
    do_reset();
    green_run(0, n);
    chk("green_hold", n, 8);
    T2 = 2'b01;
    do_reset();
    green_run(1, n);
    chk("green_pulse", n, 6);
    T2 = 2'b00;
    TL2 = 2'b11;
    do_reset();
    n = 0;
    while (n < 200 && !(m2.d == 1 && m2.ph == 3)) begin n++; tick(); end
    chk("ly_reach", n < 200, 1);
    #1 reset = 1;
    #1;
    chk("ly_rst_L2", {28'b0, L2}, 32'h8);
    chk("ly_rst_dir2", {31'b0, dir2}, 0);
    tick();
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) T2 = ((c / 500) % 2 == 1) ? 2'b11 : 2'($urandom);
      if ($urandom_range(0, 3) == 0) TL2 = ((c / 500) % 2 == 1) ? 2'b11 : 2'($urandom);
      if ($urandom_range(0, 3) == 0) T3 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) TL3 = 3'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1;
        tick();
        reset = 0;
      end else tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
